// File: rtl/fetch_queue.sv
// Instruction fetch queue: PC generator feeding a DEPTH-entry FIFO of {inst, pc}.
// Misaligned redirects park the fetcher in FAULT until an aligned redirect arrives.
module fetch_queue #(
  parameter int             XLEN     = 32,
  parameter int             INST_W   = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [INST_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fault,
  output logic [XLEN-1:0]            fault_pc
);

  // state | meaning
  // FETCH | PC advances and pushes into the queue whenever there is room
  // FAULT | misaligned redirect seen; fetch halted, queue empty
  typedef enum logic {FETCH, FAULT} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   fault_pc_next;
  logic [PW-1:0]     head, tail;
  logic              push, pop;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] last_inst;
  logic [XLEN-1:0]   last_pc;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    fault_pc_next = fault_pc;
    push          = 1'b0;
    pop           = 1'b0;
    if (redirect) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_next    = redirect_pc;
        state_next = FETCH;
      end else begin
        fault_pc_next = redirect_pc;
        state_next    = FAULT;
      end
    end else begin
      push = (state == FETCH) && (count != CW'(DEPTH));
      pop  = out_valid && out_ready;
      if (push) pc_next = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      fault_pc  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_inst <= '0;
      last_pc   <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fault_pc <= fault_pc_next;
      // Capture the presented head so outputs stay stable once the queue drains.
      if (out_valid) begin
        last_inst <= inst_mem[head];
        last_pc   <= pc_mem[head];
      end
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[tail] <= imem_data;
      pc_mem[tail]   <= pc;
    end
  end

  assign imem_addr    = pc;
  assign out_valid    = (count != '0);
  assign out_inst     = out_valid ? inst_mem[head] : last_inst;
  assign out_pc       = out_valid ? pc_mem[head]   : last_pc;
  assign out_pc_plus4 = out_pc + XLEN'(4);
  assign fault        = (state == FAULT);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, stall/saturation, redirect, fault, PC wrap, reset.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_data, redirect_pc;
  logic        redirect, out_ready, out_valid, fault;
  logic [31:0] out_inst, out_pc, out_pc_plus4, fault_pc;
  logic [2:0]  count;

  logic [31:0] imem_addr2, imem_data2, out_inst2, out_pc2, out_pc_plus42, fault_pc2;
  logic        out_ready2, out_valid2, fault2;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic [2:0]  count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_data  = imem_addr  ^ 32'hA5A5_0000;
  assign imem_data2 = imem_addr2 ^ 32'hA5A5_0000;

  fetch_queue dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .count(count), .fault(fault), .fault_pc(fault_pc)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_inst(out_inst2), .out_pc(out_pc2),
    .out_pc_plus4(out_pc_plus42), .count(count2), .fault(fault2), .fault_pc(fault_pc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; out_ready2 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b exp 0", fault); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (fault_pc !== 32'h0) begin fails++; $display("FAIL reset_fault_pc got %h exp 0", fault_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_pc_plus4 !== 32'(4*i+4) ||
          out_inst !== (32'(4*i) ^ 32'hA5A5_0000) || count !== 3'd1) begin
        fails++;
        $display("FAIL stream[%0d] got v=%0b pc=%h p4=%h inst=%h cnt=%0d exp pc=%h", i,
                 out_valid, out_pc, out_pc_plus4, out_inst, count, 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 10; i++) step();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL stall_count got %0d exp 4", count); end
    tests++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL stall_addr got %h exp 10", imem_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*i)) begin
        fails++; $display("FAIL drain[%0d] got v=%0b pc=%h exp pc=%h", i, out_valid, out_pc, 32'(4*i));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step(); step();
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL redir_pre_count got %0d exp 3", count); end
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h100 || out_pc !== 32'h0) begin
      fails++; $display("FAIL redir_flush got cnt=%0d v=%0b addr=%h pc=%h exp 0 0 100 0",
                        count, out_valid, imem_addr, out_pc);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'hA5A5_0100) begin
      fails++; $display("FAIL redir_target got v=%0b pc=%h inst=%h exp 1 100 a5a50100", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_fault();
    logic [31:0] addr_before;
    addr_before = imem_addr;
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h102 || imem_addr !== addr_before) begin
      fails++; $display("FAIL fault_enter got f=%0b fpc=%h addr=%h exp 1 102 %h", fault, fault_pc, imem_addr, addr_before);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (count !== 3'd0 || fault !== 1'b1) begin
        fails++; $display("FAIL fault_hold[%0d] got cnt=%0d f=%0b exp 0 1", i, count, fault);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h203) begin
      fails++; $display("FAIL fault_update got f=%0b fpc=%h exp 1 203", fault, fault_pc);
    end
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_exit got %0b exp 0", fault); end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      fails++; $display("FAIL fault_resume got v=%0b pc=%h exp 1 200", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready2 = 1'b1;
    tests++; if (imem_addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_reset_addr got %h exp fffffff8", imem_addr2); end
    step();
    tests++;
    if (out_pc2 !== 32'hFFFF_FFF8 || out_pc_plus42 !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap0 got pc=%h p4=%h exp fffffff8 fffffffc", out_pc2, out_pc_plus42);
    end
    step();
    tests++;
    if (out_pc2 !== 32'hFFFF_FFFC || out_pc_plus42 !== 32'h0) begin
      fails++; $display("FAIL wrap1 got pc=%h p4=%h exp fffffffc 0", out_pc2, out_pc_plus42);
    end
    step();
    tests++;
    if (out_pc2 !== 32'h0 || out_valid2 !== 1'b1) begin
      fails++; $display("FAIL wrap2 got pc=%h v=%0b exp 0 1", out_pc2, out_valid2);
    end
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); step();
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL rmid_pre got %0d exp 2", count); end
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h41; out_ready = 1'b1;
    step();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    tests++;
    if (count !== 3'd0 || imem_addr !== 32'h0 || fault !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rmid got cnt=%0d addr=%h f=%0b v=%0b exp 0 0 0 0", count, imem_addr, fault, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0; out_ready2 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
